// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
// The unit uses the slave modport; the execute stage and memory use master.
interface load_store_unit_if #(
  parameter int Width = 32
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [Width-1:0] req_addr;
  logic [Width-1:0] req_wdata;
  logic             resp_valid;
  logic [Width-1:0] resp_rdata;
  logic             resp_misaligned;
  logic             MemRead;
  logic             MemWrite;
  logic [Width-1:0] MemAddr;
  logic [Width-1:0] MemWriteData;
  logic [Width-1:0] MemReadData;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, MemReadData,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
           MemRead, MemWrite, MemAddr, MemWriteData
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, MemReadData,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
           MemRead, MemWrite, MemAddr, MemWriteData
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V byte/half/word load-store initiator for a word-wide memory without
// byte enables; sub-word stores are done as read-modify-write.
module load_store_unit #(
  parameter int Width     = 32,
  parameter int AddrWidth = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, DATA, WRITE} state_t;

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       lane_q, lane_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_mis_q, resp_mis_d;
  logic [Width-1:0] resp_rdata_q, resp_rdata_d;
  logic [Width-1:0] mem_addr_q, mem_addr_d;
  logic [Width-1:0] mem_wdata_q, mem_wdata_d;

  logic             ready;
  logic             req_fire;
  logic             f3_legal;
  logic             req_err;
  logic [4:0]       byte_shift;
  logic [15:0]      rd_lane;
  logic [Width-1:0] load_val;
  logic [Width-1:0] merge_mask;
  logic [Width-1:0] merged;
  logic             unused_addr_bits;

  // Upper address bits are dropped so accesses wrap within the memory.
  assign unused_addr_bits = ^bus.req_addr[Width-1:AddrWidth+2];

  assign ready    = rst_n && (state_q == IDLE);
  assign req_fire = bus.req_valid && ready;

  always_comb begin
    f3_legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
      default:                                f3_legal = 1'b0;
    endcase
    req_err = !f3_legal
           || ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
           || ((bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00));
  end

  // Legal halfwords have lane[0] = 0, so the byte shift also selects the halfword.
  always_comb begin
    byte_shift = {lane_q, 3'b000};
    rd_lane    = 16'(bus.MemReadData >> byte_shift);
    case (funct3_q)
      3'b000:  load_val = {{(Width-8){rd_lane[7]}}, rd_lane[7:0]};
      3'b100:  load_val = {{(Width-8){1'b0}}, rd_lane[7:0]};
      3'b001:  load_val = {{(Width-16){rd_lane[15]}}, rd_lane};
      3'b101:  load_val = {{(Width-16){1'b0}}, rd_lane};
      default: load_val = bus.MemReadData;
    endcase
    merge_mask = (funct3_q[0] ? Width'(32'h0000_FFFF) : Width'(32'h0000_00FF)) << byte_shift;
    merged     = (bus.MemReadData & ~merge_mask)
               | ((Width'(wdata_q) << byte_shift) & merge_mask);
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_mis_d   = resp_mis_q;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          lane_d   = bus.req_addr[1:0];
          wdata_d  = bus.req_wdata[15:0];
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_mis_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            mem_addr_d = {{(Width-AddrWidth){1'b0}}, bus.req_addr[AddrWidth+1:2]};
            if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
              mem_wdata_d = bus.req_wdata;
              state_d     = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: state_d = DATA;
      DATA: begin
        if (we_q) begin
          mem_wdata_d = merged;
          state_d     = WRITE;
        end else begin
          resp_valid_d = 1'b1;
          resp_mis_d   = 1'b0;
          resp_rdata_d = load_val;
          state_d      = IDLE;
        end
      end
      WRITE: begin
        resp_valid_d = 1'b1;
        resp_mis_d   = 1'b0;
        resp_rdata_d = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_mis_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_mis_q   <= resp_mis_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Strobes are gated by reset so an interrupted access never touches memory.
  assign bus.req_ready       = ready;
  assign bus.MemRead         = rst_n && (state_q == READ);
  assign bus.MemWrite        = rst_n && (state_q == WRITE);
  assign bus.MemAddr         = mem_addr_q;
  assign bus.MemWriteData    = mem_wdata_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_misaligned = resp_mis_q;
  assign bus.resp_rdata      = resp_rdata_q;

endmodule
